// File: rtl/accel_spi_reader.sv
// accel_spi_reader: SPI mode-3 master for an ADXL345-style accelerometer.
// After reset it writes DATA_FORMAT (0x31 <- 0x0B) and POWER_CTL (0x2D <- 0x08),
// then performs a 6-byte multi-byte read from 0x32 every SAMPLE_PERIOD clocks
// and presents the assembled X/Y/Z words with a one-cycle sample_valid strobe.
//
// Ports:
//   clk          system clock, all flops on its rising edge
//   rst          asynchronous active-low reset
//   spi_sclk     SPI clock, idles high
//   spi_cs_n     chip select, active low
//   spi_mosi     master data out, MSB first
//   spi_miso     slave data in, sampled on SCLK rising edges during reads
//   X/Y/Z_coordinate  last sample, {high byte, low byte}, raw two's complement
//   sample_valid one-cycle pulse when X/Y/Z update
//   init_done    high once both configuration writes have completed
module accel_spi_reader #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 10000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [15:0] X_coordinate,
  output logic [15:0] Y_coordinate,
  output logic [15:0] Z_coordinate,
  output logic        sample_valid,
  output logic        init_done
);

  localparam int unsigned CW = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned TW = $clog2(SAMPLE_PERIOD) + 1;
  localparam int unsigned HW = 7;

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 2);
  // IDLE hands over one cycle early so the READ launch lands on timer == SAMPLE_PERIOD-1.
  localparam logic [TW-1:0] TIMER_ARM = TW'(SAMPLE_PERIOD - 2);
  // Half-period index at which cs_n rises: 2N+1 for N bits.
  localparam logic [HW-1:0] WR_END    = HW'(33);
  localparam logic [HW-1:0] RD_END    = HW'(113);

  typedef enum logic [2:0] {
    ST_INIT_FMT,
    ST_GAP_FMT,
    ST_INIT_PWR,
    ST_GAP_PWR,
    ST_IDLE,
    ST_READ,
    ST_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] h_q, h_d;
  logic [15:0]   tx_q, tx_d;
  logic [47:0]   rx_q, rx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic [15:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic          valid_q, valid_d;
  logic          init_done_q, init_done_d;

  logic [15:0]   tx_load;
  logic [HW-1:0] end_h;
  logic [HW-1:0] h_next;
  logic          is_read;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    h_d         = h_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    timer_d     = timer_q + TW'(1);
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    valid_d     = 1'b0;
    init_done_d = init_done_q;

    h_next  = h_q + HW'(1);
    is_read = (state_q == ST_READ);
    tx_load = 16'h0000;
    end_h   = WR_END;

    case (state_q)
      ST_INIT_FMT: tx_load = 16'h310B;
      ST_INIT_PWR: tx_load = 16'h2D08;
      ST_READ: begin
        tx_load = 16'hF200;
        end_h   = RD_END;
      end
      default: ;
    endcase

    case (state_q)
      ST_INIT_FMT, ST_INIT_PWR, ST_READ: begin
        if (cs_n_q) begin
          // Launch: cs_n falls and the first bit is presented on the same edge.
          cs_n_d = 1'b0;
          sclk_d = 1'b1;
          tx_d   = tx_load;
          mosi_d = tx_load[15];
          cnt_d  = '0;
          h_d    = '0;
          if (is_read) timer_d = '0;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          h_d   = h_next;
          if (h_next == end_h) begin
            cs_n_d = 1'b1;
            case (state_q)
              ST_INIT_FMT: state_d = ST_GAP_FMT;
              ST_INIT_PWR: begin
                state_d     = ST_GAP_PWR;
                init_done_d = 1'b1;
              end
              default:     state_d = ST_DONE;
            endcase
          end else if (h_next[0]) begin
            // Falling edge: present the current MSB (first fall repeats the launch bit).
            sclk_d = 1'b0;
            mosi_d = tx_q[15];
          end else begin
            // Rising edge: slave samples mosi, we capture miso and advance tx.
            sclk_d = 1'b1;
            tx_d   = {tx_q[14:0], 1'b0};
            if (is_read) rx_d = {rx_q[46:0], spi_miso};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_GAP_FMT, ST_GAP_PWR: begin
        // Exit one cycle early; the next state's launch edge completes the 2*D gap.
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == ST_GAP_FMT) ? ST_INIT_PWR : ST_READ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_IDLE: begin
        if (timer_q == TIMER_ARM) state_d = ST_READ;
      end

      ST_DONE: begin
        // rx holds b0..b5 oldest-first in the top bytes.
        x_d     = {rx_q[39:32], rx_q[47:40]};
        y_d     = {rx_q[23:16], rx_q[31:24]};
        z_d     = {rx_q[7:0],   rx_q[15:8]};
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_INIT_FMT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT_FMT;
      cnt_q       <= '0;
      h_q         <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      timer_q     <= '0;
      sclk_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      h_q         <= h_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      timer_q     <= timer_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign spi_sclk     = sclk_q;
  assign spi_cs_n     = cs_n_q;
  assign spi_mosi     = mosi_q;
  assign X_coordinate = x_q;
  assign Y_coordinate = y_q;
  assign Z_coordinate = z_q;
  assign sample_valid = valid_q;
  assign init_done    = init_done_q;

endmodule
